// File: rtl/apb_sfr_bridge_pkg.sv
// Shared types and register map for the APB-to-SFR bridge and its register block.
package apb_sfr_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    localparam logic [31:0] SFR_CTRL     = 32'h0000_0000;
    localparam logic [31:0] SFR_INTR_STS = 32'h0000_0004;
    localparam logic [31:0] SFR_INTR_MSK = 32'h0000_0008;
    localparam logic [31:0] SFR_DEBUG    = 32'h0000_000C;

    localparam int SFR_NUM_REGS = 4;

    // Byte-lane merge used by register blocks sitting behind the bridge.
    function automatic logic [31:0] apply_strobe(input logic [31:0] old_word,
                                                 input logic [31:0] new_word,
                                                 input logic [3:0]  strobe);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strobe[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/apb_sfr_bridge_if.sv
// APB4 completer-side bus bundle for the SFR bridge.
interface apb_sfr_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_sfr_addr_decode.sv
// Combinational decode of an APB byte address onto the SFR word map.
module apb_sfr_addr_decode #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 4,
    parameter int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic [ADDR_WIDTH-1:0] paddr,
    output logic                  hit,
    output logic [IDX_W-1:0]      index
);

    localparam logic [ADDR_WIDTH-1:0] MAP_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

    // The full address is compared so aliases in the upper bits are rejected.
    always_comb begin
        hit   = (paddr[1:0] == 2'b00) && (paddr < MAP_LIMIT);
        index = paddr[IDX_W+1:2];
    end

endmodule

// File: rtl/apb_sfr_bridge.sv
// APB4 slave that turns each transfer into one SFR read/write request pulse.
// Optional WAIT-state timeout is enabled by defining SFR_BRIDGE_TIMEOUT_EN.
module apb_sfr_bridge
    import apb_sfr_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = SFR_NUM_REGS
`ifdef SFR_BRIDGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                    clk,
    input  logic                    reset_n,
    apb_sfr_bridge_if.slave         apb,
    output logic                    o_wr_en,
    output logic                    o_rd_en,
    output logic [ADDR_WIDTH-1:0]   o_waddr,
    output logic [ADDR_WIDTH-1:0]   o_raddr,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrobe,
    input  logic                    i_wready,
    input  logic                    i_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_rdata
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_index;
    logic [ADDR_WIDTH-1:0] dec_addr;

    apb_sfr_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_addr_decode (
        .paddr (apb.paddr),
        .hit   (dec_hit),
        .index (dec_index)
    );

    assign dec_addr = ADDR_WIDTH'({dec_index, 2'b00});

    state_t state;
    logic   req_write;

`ifdef SFR_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt;
`endif

    // Request pulses and PREADY are one-cycle strobes, so they default low each cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            req_write   <= 1'b0;
            o_wr_en     <= 1'b0;
            o_rd_en     <= 1'b0;
            o_waddr     <= '0;
            o_raddr     <= '0;
            o_wdata     <= '0;
            o_wstrobe   <= '0;
            apb.pready  <= 1'b0;
            apb.pslverr <= 1'b0;
            apb.prdata  <= '0;
`ifdef SFR_BRIDGE_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            o_wr_en     <= 1'b0;
            o_rd_en     <= 1'b0;
            apb.pready  <= 1'b0;
            apb.pslverr <= 1'b0;
            apb.prdata  <= '0;
            case (state)
                IDLE: begin
                    if (apb.psel && !apb.penable) begin
                        req_write <= apb.pwrite;
                        if (dec_hit) begin
                            state   <= REQ;
                            o_wr_en <= apb.pwrite;
                            o_rd_en <= !apb.pwrite;
                            if (apb.pwrite) begin
                                o_waddr   <= dec_addr;
                                o_wdata   <= apb.pwdata;
                                o_wstrobe <= apb.pstrb;
                            end else begin
                                o_raddr   <= dec_addr;
                                o_wstrobe <= '0;
                            end
`ifdef SFR_BRIDGE_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end else begin
                            // Unmapped or misaligned: answer directly, SFR block untouched.
                            state       <= DONE;
                            apb.pready  <= 1'b1;
                            apb.pslverr <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (req_write ? i_wready : i_rvalid) begin
                        state       <= DONE;
                        apb.pready  <= 1'b1;
                        apb.prdata  <= req_write ? '0 : i_rdata;
`ifdef SFR_BRIDGE_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_LAST) begin
                        state       <= DONE;
                        apb.pready  <= 1'b1;
                        apb.pslverr <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_sfr_bridge.sv
// Bench: apb_sfr_bridge plus a behavioural SFR register block, checked against a transfer-level model.
// Define SFR_BRIDGE_TIMEOUT_EN to also exercise the WAIT timeout.
module tb_apb_sfr_bridge;
    import apb_sfr_bridge_pkg::*;

`ifdef SFR_BRIDGE_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        o_wr_en, o_rd_en;
    logic [31:0] o_waddr, o_raddr, o_wdata;
    logic [3:0]  o_wstrobe;
    logic        i_wready, i_rvalid;
    logic [31:0] i_rdata;

    apb_sfr_bridge_if apb_bus ();

    apb_sfr_bridge dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .apb       (apb_bus),
        .o_wr_en   (o_wr_en),
        .o_rd_en   (o_rd_en),
        .o_waddr   (o_waddr),
        .o_raddr   (o_raddr),
        .o_wdata   (o_wdata),
        .o_wstrobe (o_wstrobe),
        .i_wready  (i_wready),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    logic rst_q = 1'b1;
    bit   seen_reset = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        rst_q = reset_n;
        if (!reset_n) seen_reset = 1'b1;
    end

    // Behavioural SFR register block with stall and stray-ack injection.
    logic [31:0] sfr_regs [4];
    logic sfr_stall = 1'b0, pend_w = 1'b0, pend_r = 1'b0;
    logic inject_wready = 1'b0, inject_rvalid = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            sfr_regs[0] <= 32'h0000_0005;
            sfr_regs[1] <= 32'h0000_0000;
            sfr_regs[2] <= 32'h0000_0001;
            sfr_regs[3] <= 32'h0000_0000;
            pend_w <= 1'b0; pend_r <= 1'b0;
            i_wready <= 1'b0; i_rvalid <= 1'b0; i_rdata <= '0;
        end else begin
            i_wready <= inject_wready;
            i_rvalid <= inject_rvalid;
            i_rdata  <= inject_rvalid ? 32'hDEAD_BEEF : 32'h0;
            if ((o_wr_en || pend_w) && !sfr_stall) begin
                sfr_regs[o_waddr[3:2]] <= apply_strobe(sfr_regs[o_waddr[3:2]], o_wdata, o_wstrobe);
                i_wready <= 1'b1;
                pend_w   <= 1'b0;
            end else if (o_wr_en) begin
                pend_w <= 1'b1;
            end
            if ((o_rd_en || pend_r) && !sfr_stall) begin
                i_rdata  <= sfr_regs[o_raddr[3:2]];
                i_rvalid <= 1'b1;
                pend_r   <= 1'b0;
            end else if (o_rd_en) begin
                pend_r <= 1'b1;
            end
        end
    end

    // Transfer-level model: latency rules, address map and register contents.
    logic [31:0] model_regs [4];
    bit          m_busy = 1'b0, m_hit, m_write, m_err;
    int          m_t0, m_done;
    logic [31:0] m_addr, m_wdata, m_rdata, m_mask;
    logic [3:0]  m_strb;
    bit          exp_wr, exp_rd, exp_rdy;
    int          wr_pulses = 0, rd_pulses = 0, both_pulses = 0;

    always @(negedge clk) begin
        if (seen_reset) begin
            wr_pulses   += int'(o_wr_en);
            rd_pulses   += int'(o_rd_en);
            both_pulses += int'(o_wr_en && o_rd_en);
            if (!rst_q) begin
                m_busy = 1'b0;
                model_regs[0] = 32'h5; model_regs[1] = 32'h0;
                model_regs[2] = 32'h1; model_regs[3] = 32'h0;
                checkOutput("rst_pready",    apb_bus.pready,  0);
                checkOutput("rst_pslverr",   apb_bus.pslverr, 0);
                checkOutput("rst_prdata",    apb_bus.prdata,  0);
                checkOutput("rst_o_wr_en",   o_wr_en,         0);
                checkOutput("rst_o_rd_en",   o_rd_en,         0);
                checkOutput("rst_o_waddr",   o_waddr,         0);
                checkOutput("rst_o_raddr",   o_raddr,         0);
                checkOutput("rst_o_wdata",   o_wdata,         0);
                checkOutput("rst_o_wstrobe", o_wstrobe,       0);
            end else begin
                if (!m_busy && apb_bus.psel && !apb_bus.penable) begin
                    m_busy  = 1'b1;
                    m_t0    = cyc;
                    m_write = apb_bus.pwrite;
                    m_addr  = apb_bus.paddr;
                    m_wdata = apb_bus.pwdata;
                    m_strb  = apb_bus.pstrb;
                    m_hit   = (m_addr % 4 == 0) && (m_addr < 32'(4 * SFR_NUM_REGS));
                    m_done  = m_hit ? -1 : cyc + 1;
                    m_err   = !m_hit;
                    m_rdata = 32'h0;
                end else if (m_busy && m_hit && m_done < 0 && cyc >= m_t0 + 2) begin
                    if (m_write ? i_wready : i_rvalid) begin
                        m_done  = cyc + 1;
                        m_err   = 1'b0;
                        m_rdata = m_write ? 32'h0 : model_regs[m_addr / 4];
`ifdef SFR_BRIDGE_TIMEOUT_EN
                    end else if (cyc == m_t0 + 1 + TIMEOUT) begin
                        m_done  = cyc + 1;
                        m_err   = 1'b1;
                        m_rdata = 32'h0;
`endif
                    end
                end
                exp_wr  = m_busy && m_hit &&  m_write && cyc == m_t0 + 1;
                exp_rd  = m_busy && m_hit && !m_write && cyc == m_t0 + 1;
                exp_rdy = m_busy && cyc == m_done;
                checkOutput("o_wr_en", o_wr_en,        exp_wr);
                checkOutput("o_rd_en", o_rd_en,        exp_rd);
                checkOutput("pready",  apb_bus.pready, exp_rdy);
                if (exp_wr) begin
                    checkOutput("o_waddr",   o_waddr,   m_addr);
                    checkOutput("o_wdata",   o_wdata,   m_wdata);
                    checkOutput("o_wstrobe", o_wstrobe, m_strb);
                end
                if (exp_rd) begin
                    checkOutput("o_raddr",      o_raddr,   m_addr);
                    checkOutput("o_wstrobe_rd", o_wstrobe, 0);
                end
                if (exp_rdy) begin
                    checkOutput("pslverr", apb_bus.pslverr, m_err);
                    checkOutput("prdata",  apb_bus.prdata,  m_rdata);
                    if (m_write && !m_err) begin
                        m_mask = {{8{m_strb[3]}}, {8{m_strb[2]}}, {8{m_strb[1]}}, {8{m_strb[0]}}};
                        model_regs[m_addr / 4] = (model_regs[m_addr / 4] & ~m_mask) | (m_wdata & m_mask);
                    end
                    m_busy = 1'b0;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that ends the DONE cycle.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, output logic [31:0] rdata,
                                 output logic err, output int lat);
        int  t0;
        bit  got;
        t0 = cyc;
        apb_bus.psel = 1'b1; apb_bus.penable = 1'b0; apb_bus.pwrite = wr;
        apb_bus.paddr = addr; apb_bus.pwdata = wdata; apb_bus.pstrb = strb;
        @(posedge clk); #1;
        apb_bus.penable = 1'b1;
        got = 1'b0; rdata = 32'h0; err = 1'b0; lat = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (apb_bus.pready === 1'b1) begin
                got = 1'b1; rdata = apb_bus.prdata; err = apb_bus.pslverr; lat = cyc - t0;
            end
        end
        if (!got) begin
            fails++;
            $display("[TB] FAIL pready_timeout: got no pready, expected one within 40 cycles of 0x%08h", addr);
        end
        @(posedge clk); #1;
        apb_bus.psel = 1'b0; apb_bus.penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lt, wr0, rd0, both0;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        apb_bus.psel = 1'b0; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0;
        apb_bus.paddr = '0; apb_bus.pwdata = '0; apb_bus.pstrb = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_pready_literal", apb_bus.pready, 0);
        @(posedge clk); #1;

        $display("[TB] read CTRL after reset");
        applyStimulus(1'b0, SFR_CTRL, 32'h0, 4'h0, rd, er, lt);
        checkOutput("rd_ctrl_data", rd, 32'h0000_0005);
        checkOutput("rd_ctrl_err",  er, 0);
        checkOutput("rd_ctrl_lat",  lt, 3);

        $display("[TB] write/read INTR_STS");
        applyStimulus(1'b1, SFR_INTR_STS, 32'hA5A5_0001, 4'hF, rd, er, lt);
        checkOutput("wr_sts_err", er, 0);
        checkOutput("wr_sts_lat", lt, 3);
        applyStimulus(1'b0, SFR_INTR_STS, 32'h0, 4'h0, rd, er, lt);
        checkOutput("rd_sts_data", rd, 32'hA5A5_0001);
        checkOutput("rd_sts_err",  er, 0);

        $display("[TB] partial strobe write");
        applyStimulus(1'b1, SFR_INTR_STS, 32'h0000_7700, 4'h2, rd, er, lt);
        applyStimulus(1'b0, SFR_INTR_STS, 32'h0, 4'h0, rd, er, lt);
        checkOutput("rd_sts_strobe", rd, 32'hA5A5_7701);

        $display("[TB] unmapped and misaligned accesses");
        wr0 = wr_pulses; rd0 = rd_pulses;
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, er, lt);
        checkOutput("miss_rd_err",  er, 1);
        checkOutput("miss_rd_lat",  lt, 1);
        checkOutput("miss_rd_data", rd, 0);
        applyStimulus(1'b1, 32'h0000_0006, 32'h1111_2222, 4'hF, rd, er, lt);
        checkOutput("miss_wr_err", er, 1);
        checkOutput("miss_wr_lat", lt, 1);
        applyStimulus(1'b0, 32'h8000_0004, 32'h0, 4'h0, rd, er, lt);
        checkOutput("miss_hi_err", er, 1);
        checkOutput("miss_pulses", wr_pulses + rd_pulses - wr0 - rd0, 0);

        $display("[TB] stray acks while idle");
        inject_wready = 1'b1; inject_rvalid = 1'b1;
        @(posedge clk); #1;
        inject_wready = 1'b0; inject_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("stray_idle_pready", apb_bus.pready, 0);
        @(posedge clk); #1;

        $display("[TB] stalled write with wrong-type ack");
        sfr_stall = 1'b1;
        fork
            applyStimulus(1'b1, SFR_DEBUG, 32'h1234_5678, 4'hF, rd, er, lt);
            begin
                repeat (3) @(posedge clk);
                #1 inject_rvalid = 1'b1;
                @(posedge clk);
                #1 inject_rvalid = 1'b0; sfr_stall = 1'b0;
            end
        join
        checkOutput("stall_wr_lat", lt, 6);
        checkOutput("stall_wr_err", er, 0);
        applyStimulus(1'b0, SFR_DEBUG, 32'h0, 4'h0, rd, er, lt);
        checkOutput("rd_debug_data", rd, 32'h1234_5678);

        $display("[TB] back-to-back write then read");
        wr0 = wr_pulses; rd0 = rd_pulses; both0 = both_pulses;
        applyStimulus(1'b1, SFR_DEBUG, 32'hCAFE_F00D, 4'hF, rd, er, lt);
        applyStimulus(1'b0, SFR_DEBUG, 32'h0, 4'h0, rd, er, lt);
        checkOutput("b2b_rd_data",  rd, 32'hCAFE_F00D);
        checkOutput("b2b_wr_pulse", wr_pulses - wr0, 1);
        checkOutput("b2b_rd_pulse", rd_pulses - rd0, 1);
        checkOutput("b2b_overlap",  both_pulses - both0, 0);

`ifdef SFR_BRIDGE_TIMEOUT_EN
        $display("[TB] WAIT timeout");
        sfr_stall = 1'b1;
        applyStimulus(1'b1, SFR_INTR_MSK, 32'h0000_00FF, 4'hF, rd, er, lt);
        checkOutput("tmo_err",  er, 1);
        checkOutput("tmo_lat",  lt, 2 + TIMEOUT);
        checkOutput("tmo_data", rd, 0);
`endif

        $display("[TB] reset during WAIT");
        sfr_stall = 1'b1;
        apb_bus.psel = 1'b1; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b1;
        apb_bus.paddr = SFR_INTR_MSK; apb_bus.pwdata = 32'hFFFF_FFFF; apb_bus.pstrb = 4'hF;
        @(posedge clk); #1 apb_bus.penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1; apb_bus.psel = 1'b0; apb_bus.penable = 1'b0; sfr_stall = 1'b0;
        @(negedge clk);
        checkOutput("midrst_waddr",  o_waddr,        0);
        checkOutput("midrst_pready", apb_bus.pready, 0);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b0, SFR_INTR_MSK, 32'h0, 4'h0, rd, er, lt);
        checkOutput("midrst_rd_msk", rd, 32'h0000_0001);
        checkOutput("midrst_rd_err", er, 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
